bin_to_dec_seven_segment: RTL and testbench

//  Parametrised sequential binary-to-decimal converter driving NUM_DIGITS seven-segment digits.

---
 rtl/seven_seg_pkg.sv | 18 +
 rtl/seven_seg_digit_encoder.sv | 32 +++
 rtl/bin_to_dec_seven_segment.sv | 151 +++++++++++++++
 tb/tb_bin_to_dec_seven_segment.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants, FSM state type and BCD helper for the seven-segment converter.
// Segment constants are in lit-high form (1 = segment on); output polarity is applied at the top.
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_e;

  function automatic logic [3:0] bcd_add3(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/seven_seg_digit_encoder.sv
// One decimal digit to lit-high gfedcba segments; dash takes priority over blank.
module seven_seg_digit_encoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  input  logic       dash_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (dash_i) begin
      seg_o = SEG_DASH;
    end else if (!blank_i) begin
      case (digit_i)
        4'd0:    seg_o = 7'b0111111;
        4'd1:    seg_o = 7'b0000110;
        4'd2:    seg_o = 7'b1011011;
        4'd3:    seg_o = 7'b1001111;
        4'd4:    seg_o = 7'b1100110;
        4'd5:    seg_o = 7'b1101101;
        4'd6:    seg_o = 7'b1111101;
        4'd7:    seg_o = 7'b0000111;
        4'd8:    seg_o = 7'b1111111;
        4'd9:    seg_o = 7'b1101111;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bin_to_dec_seven_segment.sv
// Sequential double-dabble binary-to-decimal converter driving NUM_DIGITS seven-segment digits.
// Optional macro SEVEN_SEG_SIGNED_EN: treat bin_number as two's complement with a leading dash.
module bin_to_dec_seven_segment
  import seven_seg_pkg::*;
#(
  parameter int IN_WIDTH   = 8,
  parameter int NUM_DIGITS = 3,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [IN_WIDTH-1:0]       bin_number,
  input  logic                      blank_lz,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow,
  output logic [7*NUM_DIGITS-1:0]   seg_out
);

  localparam int CW = $clog2(IN_WIDTH + 1);
  localparam int BW = 4 * NUM_DIGITS;

  state_e                  state_q, state_d;
  logic [IN_WIDTH-1:0]     shift_q, shift_d, mag;
  logic [BW-1:0]           bcd_q, bcd_d, bcd_adj;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    ovf_q, ovf_d, blank_q, blank_d, neg_q, neg_d, in_neg;
  logic                    done_q, done_d, ovf_out_q, ovf_out_d, ovf_fin;
  logic [7*NUM_DIGITS-1:0] seg_q, seg_d, seg_raw;
  logic [NUM_DIGITS-1:0]   dig_blank, dig_dash;
  logic                    seen;
  int unsigned             msd, dash_pos;

`ifdef SEVEN_SEG_SIGNED_EN
  // Negating -2^(IN_WIDTH-1) yields the same bit pattern, which is the correct unsigned magnitude.
  assign in_neg = bin_number[IN_WIDTH-1];
  assign mag    = in_neg ? (-bin_number) : bin_number;
`else
  assign in_neg = 1'b0;
  assign mag    = bin_number;
`endif

  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      bcd_adj[4*k +: 4] = bcd_add3(bcd_q[4*k +: 4]);
    end
  end

  // A negative value needs a free top digit for its dash, so a nonzero top digit overflows.
  always_comb begin
    ovf_fin   = ovf_q | (neg_q & (bcd_q[BW-1 -: 4] != 4'd0));
    seen      = 1'b0;
    msd       = 0;
    dig_blank = '0;
    dig_dash  = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (!seen && (bcd_q[4*(NUM_DIGITS-1-i) +: 4] != 4'd0)) begin
        msd  = NUM_DIGITS - 1 - i;
        seen = 1'b1;
      end
      dig_blank[NUM_DIGITS-1-i] = blank_q && (i != NUM_DIGITS - 1) && !seen;
    end
    dash_pos = blank_q ? (msd + 1) : (NUM_DIGITS - 1);
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      dig_dash[k] = ovf_fin | (neg_q & (k == dash_pos));
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    seven_seg_digit_encoder u_enc (
      .digit_i (bcd_q[4*g +: 4]),
      .blank_i (dig_blank[g]),
      .dash_i  (dig_dash[g]),
      .seg_o   (seg_raw[7*g +: 7])
    );
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    blank_d   = blank_q;
    neg_d     = neg_q;
    seg_d     = seg_q;
    ovf_out_d = ovf_out_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = mag;
          bcd_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          blank_d = blank_lz;
          neg_d   = in_neg;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        ovf_d   = ovf_q | bcd_adj[BW-1];
        bcd_d   = {bcd_adj[BW-2:0], shift_q[IN_WIDTH-1]};
        shift_d = shift_q << 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(IN_WIDTH - 1)) state_d = LOAD;
      end
      LOAD: begin
        seg_d     = seg_raw;
        ovf_out_d = ovf_fin;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      blank_q   <= 1'b0;
      neg_q     <= 1'b0;
      seg_q     <= '0;
      ovf_out_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      blank_q   <= blank_d;
      neg_q     <= neg_d;
      seg_q     <= seg_d;
      ovf_out_q <= ovf_out_d;
      done_q    <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign overflow = ovf_out_q;
  assign seg_out  = (ACTIVE_LOW != 0) ? ~seg_q : seg_q;

endmodule

// File: tb/tb_bin_to_dec_seven_segment.sv
// Directed self-checking bench for bin_to_dec_seven_segment (8-bit and 10-bit instances).
module tb_bin_to_dec_seven_segment;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0010000, BL = 7'b1111111, DS = 7'b0111111;

  logic        clk, reset;
  logic        start8, bl8, busy8, done8, ovf8;
  logic [7:0]  bin8;
  logic [20:0] seg8;
  logic        start10, bl10, busy10, done10, ovf10;
  logic [9:0]  bin10;
  logic [20:0] seg10;

  int checks   = 0;
  int failures = 0;
  int lat, bc, n;

  bin_to_dec_seven_segment dut (
    .clk(clk), .reset(reset), .start(start8), .bin_number(bin8), .blank_lz(bl8),
    .busy(busy8), .done(done8), .overflow(ovf8), .seg_out(seg8)
  );

  bin_to_dec_seven_segment #(.IN_WIDTH(10)) dut10 (
    .clk(clk), .reset(reset), .start(start10), .bin_number(bin10), .blank_lz(bl10),
    .busy(busy10), .done(done10), .overflow(ovf10), .seg_out(seg10)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input bit sel, input int val, input logic bl, output int l, output int b);
    if (sel) begin bin10 = 10'(val); bl10 = bl; start10 = 1'b1; end
    else begin bin8 = 8'(val); bl8 = bl; start8 = 1'b1; end
    tick();
    start8 = 1'b0;
    start10 = 1'b0;
    l = 0;
    b = 0;
    if (sel ? busy10 : busy8) b++;
    while (!(sel ? done10 : done8) && l < 40) begin
      tick();
      l++;
      if (sel ? busy10 : busy8) b++;
    end
  endtask

  initial begin
    reset = 1'b1; start8 = 1'b0; bl8 = 1'b0; bin8 = '0;
    start10 = 1'b0; bl10 = 1'b0; bin10 = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_busy", busy8, 1'b0);
    check("rst_done", done8, 1'b0);
    check("rst_ovf", ovf8, 1'b0);
    check("rst_seg", seg8, 21'h1FFFFF);

    // 255, no blanking
    run(0, 255, 1'b0, lat, bc);
    check("t1_latency", lat, 9);
    check("t1_busy_cycles", bc, 9);
    check("t1_seg", seg8, {S2, S5, S5});
    check("t1_ovf", ovf8, 1'b0);
    tick();
    check("t1_done_pulse", done8, 1'b0);
    check("t1_seg_hold", seg8, {S2, S5, S5});

    // leading-zero blanking
    run(0, 7, 1'b1, lat, bc);
    check("t2_seg7", seg8, {BL, BL, S7});
    run(0, 0, 1'b1, lat, bc);
    check("t2_seg0", seg8, {BL, BL, S0});
    run(0, 5, 1'b0, lat, bc);
    check("t2_seg5_noblank", seg8, {S0, S0, S5});
    run(0, 100, 1'b1, lat, bc);
    check("t2_seg100", seg8, {S1, S0, S0});

    // 10-bit instance: overflow boundary
    run(1, 1000, 1'b0, lat, bc);
    check("t3_latency", lat, 11);
    check("t3_busy_cycles", bc, 11);
    check("t3_seg1000", seg10, {DS, DS, DS});
    check("t3_ovf1000", ovf10, 1'b1);
    run(1, 999, 1'b1, lat, bc);
    check("t3_seg999", seg10, {S9, S9, S9});
    check("t3_ovf999", ovf10, 1'b0);

    // start while busy is ignored, bin_number change ignored
    bin8 = 8'd42; bl8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    n = 0;
    check("t4_busy", busy8, 1'b1);
    check("t4_seg_hold", seg8, {S1, S0, S0});
    tick(); n++; tick(); n++; tick(); n++;
    start8 = 1'b1; bin8 = 8'd99;
    tick(); n++;
    start8 = 1'b0;
    while (!done8 && n < 40) begin tick(); n++; end
    check("t4_latency", n, 9);
    check("t4_seg42", seg8, {S0, S4, S2});
    run(0, 13, 1'b0, lat, bc);
    check("t4_b2b_latency", lat, 9);
    check("t4_seg13", seg8, {S0, S1, S3});

    // asynchronous reset during SHIFT
    bin8 = 8'd200; bl8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    check("t5_busy", busy8, 1'b0);
    check("t5_done", done8, 1'b0);
    check("t5_seg", seg8, 21'h1FFFFF);
    check("t5_ovf", ovf8, 1'b0);
    tick();
    reset = 1'b0;
    run(0, 58, 1'b1, lat, bc);
    check("t5_latency", lat, 9);
    check("t5_seg58", seg8, {BL, S5, S8});

`ifdef SEVEN_SEG_SIGNED_EN
    run(0, 8'hD3, 1'b1, lat, bc);
    check("t6_seg_m45", seg8, {DS, S4, S5});
    check("t6_ovf_m45", ovf8, 1'b0);
    run(0, 8'h80, 1'b1, lat, bc);
    check("t6_seg_m128", seg8, {DS, DS, DS});
    check("t6_ovf_m128", ovf8, 1'b1);
    run(0, 8'hFB, 1'b0, lat, bc);
    check("t6_seg_m5", seg8, {DS, S0, S5});
    run(0, 127, 1'b1, lat, bc);
    check("t6_seg_127", seg8, {S1, S2, S7});
    check("t6_ovf_127", ovf8, 1'b0);
`else
    run(0, 8'hD3, 1'b1, lat, bc);
    check("t6_seg_211", seg8, {S2, S1, S1});
    run(0, 8'h80, 1'b0, lat, bc);
    check("t6_seg_128", seg8, {S1, S2, S8});
    check("t6_ovf_128", ovf8, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
